// File: rtl/fsub_seq_if.sv
// Operand/result handshake bundle for the sequential FP subtractor.
// Producer drives operands and out_ready; the unit drives the rest.
interface fsub_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;

  modport master (
    output in_valid, x1, x2, out_ready,
    input  in_ready, out_valid, y, ovf
  );

  modport slave (
    input  in_valid, x1, x2, out_ready,
    output in_ready, out_valid, y, ovf
  );
endinterface

// File: rtl/fsub_seq.sv
// Multi-cycle single-precision subtractor y = x1 - x2, round-to-nearest-even.
// Stages: align, add/sub, normalize, round, then a registered result.
module fsub_seq #(
  parameter bit FTZ = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  fsub_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ALIGN, ADDSUB, NORM, ROUND, DONE
  } state_t;

  state_t st;

  logic        in_ready_q;
  logic        out_valid_q;
  logic [31:0] y_q;
  logic        ovf_q;

  logic [31:0] ra, rb;
  logic        spec;
  logic [31:0] sval;
  logic        sgn, zsgn, sub;
  logic [7:0]  ebig;
  logic [25:0] mb, ms;
  logic        stk;
  logic [27:0] sum;
  logic [26:0] nm;
  logic [9:0]  ne;
  logic        zr, zs;
  logic [9:0]  rexp;
  logic [22:0] rman;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.ovf       = ovf_q;

  // align stage operand analysis
  logic [7:0]  ea, eb, e_big, e_sml, dd;
  logic [22:0] fa, fb, f_big, f_sml;
  logic        a_nan, b_nan, a_inf, b_inf, a_ge, s_big;
  logic [4:0]  dsat;
  logic [51:0] shv;
  logic        sp_n;
  logic [31:0] sv_n;

  always_comb begin
    ea    = ra[30:23];
    eb    = rb[30:23];
    fa    = (FTZ && ea == 8'd0) ? 23'd0 : ra[22:0];
    fb    = (FTZ && eb == 8'd0) ? 23'd0 : rb[22:0];
    a_nan = (ea == 8'hFF) && (fa != 23'd0);
    b_nan = (eb == 8'hFF) && (fb != 23'd0);
    a_inf = (ea == 8'hFF) && (fa == 23'd0);
    b_inf = (eb == 8'hFF) && (fb == 23'd0);
    a_ge  = {ea, fa} >= {eb, fb};
    e_big = a_ge ? ea : eb;
    e_sml = a_ge ? eb : ea;
    f_big = a_ge ? fa : fb;
    f_sml = a_ge ? fb : fa;
    s_big = a_ge ? ra[31] : rb[31];
    dd    = e_big - e_sml;
    dsat  = (dd > 8'd31) ? 5'd31 : dd[4:0];
    // low half of the shifted word catches every bit pushed out
    shv   = {e_sml != 8'd0, f_sml, 2'b00, 26'd0} >> dsat;
    sp_n  = a_nan | b_nan | a_inf | b_inf;
    if (a_nan | b_nan | (a_inf & b_inf & (ra[31] != rb[31])))
      sv_n = 32'h7FC0_0000;
    else if (a_inf)
      sv_n = {ra[31], 8'hFF, 23'd0};
    else
      sv_n = {rb[31], 8'hFF, 23'd0};
  end

  function automatic logic [4:0] lzc(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd26;
    for (int i = 0; i <= 26; i++)
      if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  logic [4:0]  lz;
  logic [26:0] nsh;
  logic [9:0]  nexp;

  always_comb begin
    lz   = lzc(sum[26:0]);
    nsh  = sum[26:0] << lz;
    nexp = {2'b00, ebig} - {5'd0, lz};
  end

  // bit 3 is the result lsb, bit 2 guard, bits 1:0 fold into sticky
  logic        up;
  logic [24:0] rm;

  always_comb begin
    up = nm[2] & (nm[3] | nm[1] | nm[0]);
    rm = {1'b0, nm[26:3]} + {24'd0, up};
  end

  logic [31:0] py;
  logic        po;

  always_comb begin
    py = {sgn, rexp[7:0], rman};
    po = 1'b0;
    if (spec) begin
      py = sval;
    end else if (zr) begin
      py = {zs, 31'd0};
    end else if (rexp >= 10'd255) begin
      py = {sgn, 8'hFF, 23'd0};
      po = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_q         <= 32'd0;
      ovf_q       <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (bus.in_valid) begin
            ra         <= bus.x1;
            rb         <= {~bus.x2[31], bus.x2[30:0]};
            in_ready_q <= 1'b0;
            st         <= ALIGN;
          end
        end
        ALIGN: begin
          spec <= sp_n;
          sval <= sv_n;
          sgn  <= s_big;
          zsgn <= ra[31] & rb[31];
          sub  <= ra[31] ^ rb[31];
          ebig <= e_big;
          mb   <= {e_big != 8'd0, f_big, 2'b00};
          ms   <= shv[51:26];
          stk  <= |shv[25:0];
          st   <= ADDSUB;
        end
        ADDSUB: begin
          // sticky rides as an extra lsb so borrows stay exact
          if (sub)
            sum <= {1'b0, mb, 1'b0} - {1'b0, ms, stk};
          else
            sum <= {1'b0, mb, 1'b0} + {1'b0, ms, stk};
          st <= NORM;
        end
        NORM: begin
          zs <= sgn;
          if (sum == 28'd0) begin
            zr <= 1'b1;
            zs <= zsgn;
            nm <= 27'd0;
            ne <= 10'd0;
          end else if (sum[27]) begin
            zr <= 1'b0;
            nm <= {sum[27:2], sum[1] | sum[0]};
            ne <= {2'b00, ebig} + 10'd1;
          end else begin
            zr <= ($signed(nexp) <= 10'sd0);
            nm <= nsh;
            ne <= nexp;
          end
          st <= ROUND;
        end
        ROUND: begin
          rexp <= rm[24] ? ne + 10'd1 : ne;
          rman <= rm[24] ? rm[23:1] : rm[22:0];
          st   <= DONE;
        end
        DONE: begin
          if (!out_valid_q) begin
            y_q         <= py;
            ovf_q       <= po;
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            st          <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          st          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsub_seq.sv
// Self-checking bench for fsub_seq: directed vectors, handshake corners,
// and random operands against a real-arithmetic reference model.
module tb_fsub_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fsub_seq_if bus ();

  fsub_seq #(.FTZ(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        o;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // exact double difference (operands kept close), rounded to single RNE
  function automatic logic [32:0] ref_sub(input logic [31:0] a,
                                          input logic [31:0] b);
    real         r;
    logic [63:0] d;
    int          e;
    int          m;
    r = s2r(a) - s2r(b);
    if (r == 0.0) return 33'd0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    m = int'({1'b1, d[51:29]});
    if (d[28] && ((|d[27:0]) || m[0])) m = m + 1;
    if (m == (1 << 24)) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {1'b1, d[63], 8'hFF, 23'd0};
    if (e <= 0) return {1'b0, d[63], 31'd0};
    return {1'b0, d[63], e[7:0], m[22:0]};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] ry, output logic ro,
                        output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    bus.x1 = a;
    bus.x2 = b;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.x1 = $urandom;
    bus.x2 = $urandom;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
    ry = bus.y;
    ro = bus.ovf;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ry, a, b, yh;
    logic        ro;
    logic [32:0] ex;
    int          lat, n, ea, eb;

    tv.push_back('{"3m1",      32'h40400000, 32'h3F800000, 32'h40000000, 1'b0});
    tv.push_back('{"1m1",      32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0});
    tv.push_back('{"nz_m_pz",  32'h80000000, 32'h00000000, 32'h80000000, 1'b0});
    tv.push_back('{"1m_ulp",   32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 1'b0});
    tv.push_back('{"tie_even", 32'h3F800000, 32'hB3800000, 32'h3F800000, 1'b0});
    tv.push_back('{"rnd_up",   32'h3F800000, 32'hB3C00000, 32'h3F800001, 1'b0});
    tv.push_back('{"ovf",      32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1});
    tv.push_back('{"inf_inf",  32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0});
    tv.push_back('{"inf_ninf", 32'h7F800000, 32'hFF800000, 32'h7F800000, 1'b0});
    tv.push_back('{"nan_in",   32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0});
    tv.push_back('{"den_in",   32'h00000001, 32'h3F800000, 32'hBF800000, 1'b0});
    tv.push_back('{"1m_inf",   32'h3F800000, 32'h7F800000, 32'hFF800000, 1'b0});
    tv.push_back('{"far_sat",  32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0});
    tv.push_back('{"big_m1",   32'h4B800000, 32'h3F800000, 32'h4B7FFFFF, 1'b0});
    tv.push_back('{"add15",    32'h3FC00000, 32'hBFC00000, 32'h40400000, 1'b0});

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.x1 = 32'd0;
    bus.x2 = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_y", bus.y, 32'd0);
    chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);

    foreach (tv[i]) begin
      run_op(tv[i].a, tv[i].b, ry, ro, lat);
      chk({tv[i].nm, "_y"}, ry, tv[i].y);
      chk({tv[i].nm, "_ovf"}, {31'd0, ro}, {31'd0, tv[i].o});
      chk({tv[i].nm, "_lat"}, 32'(lat), 32'd5);
      if (i == 0) begin
        chk("pulse_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("pulse_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("pulse_ovf_clr", {31'd0, bus.ovf}, 32'd0);
      end
    end

    // back-pressure: result held, second request ignored until drained
    @(negedge clk);
    bus.x1 = 32'h40400000;
    bus.x2 = 32'h3F800000;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_lat", 32'(n), 32'd5);
    yh = bus.y;
    chk("bp_y", yh, 32'h40000000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.x1 = 32'h3F800000;
      bus.x2 = 32'hB3C00000;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold_valid%0d", k), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("bp_hold_y%0d", k), bus.y, yh);
      chk($sformatf("bp_hold_rdy%0d", k), {31'd0, bus.in_ready}, 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_drain_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_drain_rdy", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("bp_second_acc", {31'd0, bus.in_ready}, 32'd0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_second_lat", 32'(n), 32'd5);
    chk("bp_second_y", bus.y, 32'h3F800001);
    @(posedge clk);
    #1;

    // reset while the operation sits in normalize
    @(negedge clk);
    bus.x1 = 32'h3F800000;
    bus.x2 = 32'h33800000;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_y", bus.y, 32'd0);
    chk("mid_rst_ovf", {31'd0, bus.ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) n++;
    end
    chk("mid_rst_stale", 32'(n), 32'd0);
    run_op(32'h40400000, 32'h3F800000, ry, ro, lat);
    chk("post_rst_y", ry, 32'h40000000);
    chk("post_rst_lat", 32'(lat), 32'd5);

    // random normal operands with exponents within 25 of each other
    for (int i = 0; i < 300; i++) begin
      ea = int'($urandom_range(200, 40));
      eb = ea + int'($urandom_range(50, 0)) - 25;
      a = {1'($urandom), 8'(ea), 23'($urandom)};
      if (i % 16 == 0)
        b = a;
      else
        b = {1'($urandom), 8'(eb), 23'($urandom)};
      ex = ref_sub(a, b);
      run_op(a, b, ry, ro, lat);
      chk($sformatf("rnd%0d_y(%08h-%08h)", i, a, b), ry, ex[31:0]);
      chk($sformatf("rnd%0d_ovf", i), {31'd0, ro}, {31'd0, ex[32]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
